detector_jogada_botoes: RTL and testbench
=========================================

Name: detector_jogada_botoes

Overview:
- Input conditioning stage directly upstream of the game controller.
- Synchronizes and debounces the 4 raw player buttons, then accepts exactly one press per physical push.
- Presents the press as a registered one-hot code plus a single-cycle jogada_feita pulse, which the controller's tem_jogada/comparison logic consumes.
- Rejects multi-button presses and ignores held buttons until they are released and that release is debounced.

Parameters:
DEBOUNCE_CICLOS, 5, consecutive identical synchronized samples required to accept a press or a release (min 2).
LARGURA_CONT, 4, width of the debounce counter; must hold DEBOUNCE_CICLOS-1.

Ports:
clock  input  1  system clock (10 kHz in the game).
reset  input  1  asynchronous, active-low (asserted at 0).
habilita  input  1  controller accepts plays only while 1.
zera  input  1  synchronous clear of jogada; used at new game/round.
botoes  input  4  raw, asynchronous button levels.
jogada  output  4  last accepted one-hot button code (registered).
jogada_feita  output  1  one-cycle pulse: valid press accepted.
jogada_invalida  output  1  one-cycle pulse: stable press with 0 or more than 1 bit set.
tem_jogada  output  1  level: a debounced press is currently held.
db_estado  output  3  current FSM state code, for debug display.

Behaviour:
- Reset (reset=0, asynchronous) clears everything:
  - state=OCIOSO.
  - Synchronizer flops, capture register and counter = 0.
  - jogada=0000.
  - jogada_feita, jogada_invalida and tem_jogada = 0.
- Synchronizer: two flops on botoes; the logic below uses only the second stage, called s.
- FSM encoding: OCIOSO=0, ESTABILIZA=1, PRESSIONADO=2, ESPERA_SOLTAR=3, ESTABILIZA_SOLTURA=4.
- OCIOSO:
  - If habilita=1 and s≠0: capture s into cap, cnt=0, go ESTABILIZA.
  - Else stay.
- ESTABILIZA:
  - If habilita=0: go ESPERA_SOLTAR.
  - Else if s≠cap (includes s=0): go OCIOSO (bounce rejected, no pulse).
  - Else if cnt=DEBOUNCE_CICLOS-1: go PRESSIONADO.
  - Else cnt++.
  - On the edge entering PRESSIONADO, if cap is one-hot then jogada<=cap.
- PRESSIONADO:
  - Lasts 1 cycle, then go ESPERA_SOLTAR.
  - Moore outputs: jogada_feita=1 if cap is one-hot, else jogada_invalida=1.
  - jogada is unchanged on an invalid press.
- ESPERA_SOLTAR:
  - If s=0: cnt=0, go ESTABILIZA_SOLTURA.
  - Else stay; the state ignores habilita.
- ESTABILIZA_SOLTURA:
  - If s≠0: go ESPERA_SOLTAR.
  - Else if cnt=DEBOUNCE_CICLOS-1: go OCIOSO.
  - Else cnt++.
- tem_jogada=1 in PRESSIONADO and ESPERA_SOLTAR; 0 elsewhere.
- Latency:
  - Call e0 the first edge at which the raw press is sampled.
  - The state enters ESTABILIZA at e2.
  - The state enters PRESSIONADO at e(2+DEBOUNCE_CICLOS).
  - The pulse is high for exactly the following cycle; with the default of 5 that is after edge e7.
  - Minimum accepted hold is DEBOUNCE_CICLOS+1 edges; shorter presses give no pulse.
- zera:
  - Clears jogada to 0000 at the next edge and has priority over a simultaneous capture.
  - Does not affect the FSM.
- Held button:
  - Exactly one jogada_feita per push, regardless of hold length.
  - A new press is accepted only after s=0 for DEBOUNCE_CICLOS cycles.
- Button change while held (e.g. 0001→0011 in ESPERA_SOLTAR): no new pulse.
- habilita falling mid-debounce: no pulse is produced, and that push is consumed.
- Reset mid-operation: immediate return to OCIOSO; a button still held after reset release is treated as a fresh press.
- Counter arithmetic: unsigned and saturating by construction; never exceeds DEBOUNCE_CICLOS-1.

Test Plan:
- Reset then press botoes=0100 for 10 cycles, habilita=1 -> jogada_feita high exactly one cycle after edge e7, jogada=0100, tem_jogada=1 until the release is detected, db_estado returns to 0.
- Bounce: 0010 for 3 cycles, 0000 for 1, 0010 for 10 -> no pulse during the bounce; single pulse with jogada=0010 only after the final stable run.
- Press 0001 held 2000 cycles -> exactly one jogada_feita; a second 0001 press after 10 released cycles -> second pulse.
- Press 0101 for 10 cycles -> jogada_invalida one cycle, jogada_feita never asserted, jogada keeps its previous value (0100).
- habilita=0 while 1000 is pressed 10 cycles -> no pulse; raise habilita while still held -> still no pulse until release and a re-press.
- reset=0 during ESTABILIZA, and zera=1 after a valid play -> outputs 0 and state 0 immediately on reset; jogada=0000 one edge after zera with no spurious pulse.

Source files
------------

// File: rtl/detector_jogada_botoes.sv
// -----------------------------------------------------------------------------
// detector_jogada_botoes
//
// This module conditions the four player buttons for the game controller.
// It synchronizes the raw button levels and debounces them. It then accepts
// exactly one press per physical push. A valid press is reported as a one-hot
// code together with a single-cycle jogada_feita pulse. A press with zero
// buttons or with more than one button is reported with jogada_invalida.
// A held button is ignored until its release has also been debounced.
//
// Parameters:
//   DEBOUNCE_CICLOS  consecutive identical samples needed to accept a press
//                    or a release (min 2)
//   LARGURA_CONT     debounce counter width; must hold DEBOUNCE_CICLOS-1
//
// Ports:
//   clock            system clock
//   reset            asynchronous reset, active low
//   habilita         presses are accepted only while this is 1
//   zera             synchronous clear of jogada; has priority over a capture
//   botoes[3:0]      raw, asynchronous button levels
//   jogada[3:0]      last accepted one-hot button code (registered)
//   jogada_feita     one-cycle pulse: a valid press was accepted
//   jogada_invalida  one-cycle pulse: a stable press was not one-hot
//   tem_jogada       level: a debounced press is currently held
//   db_estado[2:0]   current FSM state code, for the debug display
// -----------------------------------------------------------------------------
module detector_jogada_botoes #(
    parameter int DEBOUNCE_CICLOS = 5,
    parameter int LARGURA_CONT    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic       zera,
    input  logic [3:0] botoes,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       jogada_invalida,
    output logic       tem_jogada,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        OCIOSO             = 3'd0,
        ESTABILIZA         = 3'd1,
        PRESSIONADO        = 3'd2,
        ESPERA_SOLTAR      = 3'd3,
        ESTABILIZA_SOLTURA = 3'd4
    } estado_t;

    localparam logic [LARGURA_CONT-1:0] CONT_MAX = LARGURA_CONT'(DEBOUNCE_CICLOS - 1);

    estado_t                 estado, estado_prox;
    logic [3:0]              sync1, s;
    logic [3:0]              cap, cap_prox;
    logic [LARGURA_CONT-1:0] cnt, cnt_prox;
    logic                    carrega;
    logic                    cap_onehot;

    // Two-flop synchronizer. Only the second stage (s) is used downstream.
    // NOTE: every register here uses non-blocking assignment. This ensures
    // that s always sees the previous value of sync1 and that the two stages
    // do not collapse into one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 4'b0000;
            s     <= 4'b0000;
        end else begin
            sync1 <= botoes;
            s     <= sync1;
        end
    end

    // A non-zero value with no second bit set is one-hot.
    assign cap_onehot = (cap != 4'b0000) && ((cap & (cap - 4'd1)) == 4'b0000);

    // State, capture and counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
            cap    <= 4'b0000;
            cnt    <= '0;
        end else begin
            estado <= estado_prox;
            cap    <= cap_prox;
            cnt    <= cnt_prox;
        end
    end

    // Next-state logic. The counter only advances while it is below CONT_MAX,
    // so it can never wrap or exceed DEBOUNCE_CICLOS-1.
    always_comb begin
        // NOTE: every signal is given a default first. This prevents any path
        // through the case statement from inferring a latch.
        estado_prox = estado;
        cap_prox    = cap;
        cnt_prox    = cnt;
        carrega     = 1'b0;

        unique case (estado)
            OCIOSO: begin
                if (habilita && (s != 4'b0000)) begin
                    cap_prox    = s;
                    cnt_prox    = '0;
                    estado_prox = ESTABILIZA;
                end
            end

            ESTABILIZA: begin
                if (!habilita) begin
                    // The push is consumed without a pulse; wait for release.
                    estado_prox = ESPERA_SOLTAR;
                end else if (s != cap) begin
                    estado_prox = OCIOSO;
                end else if (cnt == CONT_MAX) begin
                    estado_prox = PRESSIONADO;
                    carrega     = cap_onehot;
                end else begin
                    cnt_prox = cnt + LARGURA_CONT'(1);
                end
            end

            PRESSIONADO: begin
                estado_prox = ESPERA_SOLTAR;
            end

            ESPERA_SOLTAR: begin
                if (s == 4'b0000) begin
                    cnt_prox    = '0;
                    estado_prox = ESTABILIZA_SOLTURA;
                end
            end

            ESTABILIZA_SOLTURA: begin
                if (s != 4'b0000) begin
                    estado_prox = ESPERA_SOLTAR;
                end else if (cnt == CONT_MAX) begin
                    estado_prox = OCIOSO;
                end else begin
                    cnt_prox = cnt + LARGURA_CONT'(1);
                end
            end

            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    // The accepted code register. zera wins over a capture on the same edge.
    // An invalid press leaves the previous code in place.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            jogada <= 4'b0000;
        end else if (zera) begin
            jogada <= 4'b0000;
        end else if (carrega) begin
            jogada <= cap;
        end
    end

    // Moore outputs, decoded from the state register alone.
    assign jogada_feita    = (estado == PRESSIONADO) && cap_onehot;
    assign jogada_invalida = (estado == PRESSIONADO) && !cap_onehot;
    assign tem_jogada      = (estado == PRESSIONADO) || (estado == ESPERA_SOLTAR);
    assign db_estado       = estado;

endmodule

// File: tb/tb_detector_jogada_botoes.sv
// -----------------------------------------------------------------------------
// tb_detector_jogada_botoes
//
// This is the self-checking bench for detector_jogada_botoes, which runs with
// the default parameters.
//
// The main stimulus is a table of segments. Each segment holds the buttons at
// one value for a number of cycles and then checks the state, the code and
// the level output. Every pulse that a segment should cause is queued when
// that segment is driven. A monitor pops the queue on each pulse it sees and
// compares the pulse against the queued entry. Hand-written sequences cover
// exact latency, reset during debounce and zera priority.
// -----------------------------------------------------------------------------
module tb_detector_jogada_botoes;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic       zera;
    logic [3:0] botoes;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       jogada_invalida;
    logic       tem_jogada;
    logic [2:0] db_estado;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       invalida;
        logic [3:0] jogada;
    } pulso_t;

    pulso_t esperado[$];

    typedef struct {
        logic [3:0] botoes;
        logic       habilita;
        int         ciclos;
        logic       push_ok;
        logic       push_inv;
        logic [3:0] exp_jogada;
        logic [2:0] exp_estado;
        logic       exp_tem;
    } vetor_t;

    vetor_t tabela[19];

    detector_jogada_botoes dut (
        .clock           (clock),
        .reset           (reset),
        .habilita        (habilita),
        .zera            (zera),
        .botoes          (botoes),
        .jogada          (jogada),
        .jogada_feita    (jogada_feita),
        .jogada_invalida (jogada_invalida),
        .tem_jogada      (tem_jogada),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] exigido);
        checks++;
        if (atual !== exigido) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nome, atual, exigido, $time);
        end
    endtask

    // Each tick crosses one rising edge. It then settles just after the next
    // falling edge, after the monitor has already sampled that falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            #1;
        end
    endtask

    // The monitor samples the outputs on each falling edge, midway between
    // rising edges.
    always @(negedge clock) begin
        if (jogada_feita && jogada_invalida)
            check("both_pulses", 32'(1), 32'(0));
        if (jogada_feita || jogada_invalida) begin
            if (esperado.size() == 0) begin
                check("unexpected_pulse", {28'd0, jogada_invalida, 3'd0} | 32'(jogada), 32'hFFFF);
            end else begin
                pulso_t p;
                p = esperado.pop_front();
                check("pulse_kind", 32'(jogada_invalida), 32'(p.invalida));
                check("pulse_jogada", 32'(jogada), 32'(p.jogada));
            end
        end
    end

    task automatic push_pulso(input logic inv, input logic [3:0] j);
        pulso_t p;
        p.invalida = inv;
        p.jogada   = j;
        esperado.push_back(p);
    endtask

    initial begin
        // Table rows: {botoes, habilita, cycles, push_ok, push_inv, jogada, state, tem}.
        tabela[0]  = '{4'b0101, 1'b1, 10,   1'b0, 1'b1, 4'b0100, 3'd3, 1'b1}; // invalid press
        tabela[1]  = '{4'b0000, 1'b1, 10,   1'b0, 1'b0, 4'b0100, 3'd0, 1'b0};
        tabela[2]  = '{4'b0010, 1'b1, 3,    1'b0, 1'b0, 4'b0100, 3'd1, 1'b0}; // bounce
        tabela[3]  = '{4'b0000, 1'b1, 1,    1'b0, 1'b0, 4'b0100, 3'd1, 1'b0};
        tabela[4]  = '{4'b0010, 1'b1, 10,   1'b1, 1'b0, 4'b0010, 3'd3, 1'b1};
        tabela[5]  = '{4'b0000, 1'b1, 10,   1'b0, 1'b0, 4'b0010, 3'd0, 1'b0};
        tabela[6]  = '{4'b0001, 1'b1, 2000, 1'b1, 1'b0, 4'b0001, 3'd3, 1'b1}; // long hold
        tabela[7]  = '{4'b0000, 1'b1, 10,   1'b0, 1'b0, 4'b0001, 3'd0, 1'b0};
        tabela[8]  = '{4'b0001, 1'b1, 10,   1'b1, 1'b0, 4'b0001, 3'd3, 1'b1};
        tabela[9]  = '{4'b0011, 1'b1, 10,   1'b0, 1'b0, 4'b0001, 3'd3, 1'b1}; // change while held
        tabela[10] = '{4'b0000, 1'b1, 10,   1'b0, 1'b0, 4'b0001, 3'd0, 1'b0};
        tabela[11] = '{4'b1000, 1'b0, 10,   1'b0, 1'b0, 4'b0001, 3'd0, 1'b0}; // disabled
        tabela[12] = '{4'b0000, 1'b0, 5,    1'b0, 1'b0, 4'b0001, 3'd0, 1'b0};
        tabela[13] = '{4'b1000, 1'b1, 3,    1'b0, 1'b0, 4'b0001, 3'd1, 1'b0};
        tabela[14] = '{4'b1000, 1'b0, 10,   1'b0, 1'b0, 4'b0001, 3'd3, 1'b1}; // drop mid-debounce
        tabela[15] = '{4'b1000, 1'b1, 10,   1'b0, 1'b0, 4'b0001, 3'd3, 1'b1};
        tabela[16] = '{4'b0000, 1'b1, 10,   1'b0, 1'b0, 4'b0001, 3'd0, 1'b0};
        tabela[17] = '{4'b1000, 1'b1, 10,   1'b1, 1'b0, 4'b1000, 3'd3, 1'b1};
        tabela[18] = '{4'b0000, 1'b1, 10,   1'b0, 1'b0, 4'b1000, 3'd0, 1'b0};

        reset    = 1'b0;
        habilita = 1'b0;
        zera     = 1'b0;
        botoes   = 4'b0000;
        #1;
        check("rst_estado", 32'(db_estado), 32'(0));
        check("rst_jogada", 32'(jogada), 32'(0));
        check("rst_outs", {29'd0, jogada_feita, jogada_invalida, tem_jogada}, 32'(0));
        tick(3);
        reset    = 1'b1;
        habilita = 1'b1;
        tick(2);

        // Exact latency: the pulse must appear only after edge e7.
        botoes = 4'b0100;
        push_pulso(1'b0, 4'b0100);
        for (int k = 0; k < 7; k++) begin
            tick(1);
            check("lat_no_pulse_early", 32'(jogada_feita), 32'(0));
        end
        tick(1);
        check("lat_pulse_e7", 32'(jogada_feita), 32'(1));
        check("lat_jogada", 32'(jogada), 32'(4'b0100));
        check("lat_tem", 32'(tem_jogada), 32'(1));
        check("lat_estado", 32'(db_estado), 32'(2));
        tick(1);
        check("lat_pulse_end", 32'(jogada_feita), 32'(0));
        check("lat_estado_wait", 32'(db_estado), 32'(3));
        tick(1);
        botoes = 4'b0000;
        tick(10);
        check("lat_release_estado", 32'(db_estado), 32'(0));
        check("lat_release_tem", 32'(tem_jogada), 32'(0));
        check("lat_queue", 32'(esperado.size()), 32'(0));

        // Table-driven segments.
        for (int i = 0; i < 19; i++) begin
            botoes   = tabela[i].botoes;
            habilita = tabela[i].habilita;
            if (tabela[i].push_ok)  push_pulso(1'b0, tabela[i].exp_jogada);
            if (tabela[i].push_inv) push_pulso(1'b1, tabela[i].exp_jogada);
            tick(tabela[i].ciclos);
            check($sformatf("row%0d_estado", i), 32'(db_estado), 32'(tabela[i].exp_estado));
            check($sformatf("row%0d_jogada", i), 32'(jogada), 32'(tabela[i].exp_jogada));
            check($sformatf("row%0d_tem", i), 32'(tem_jogada), 32'(tabela[i].exp_tem));
            check($sformatf("row%0d_queue", i), 32'(esperado.size()), 32'(0));
        end

        // Reset during ESTABILIZA. The held button then counts as a fresh press.
        habilita = 1'b1;
        botoes   = 4'b0010;
        tick(3);
        check("mid_estabiliza", 32'(db_estado), 32'(1));
        reset = 1'b0;
        #1;
        check("mid_rst_estado", 32'(db_estado), 32'(0));
        check("mid_rst_jogada", 32'(jogada), 32'(0));
        check("mid_rst_outs", {29'd0, jogada_feita, jogada_invalida, tem_jogada}, 32'(0));
        tick(2);
        reset = 1'b1;
        push_pulso(1'b0, 4'b0010);
        tick(10);
        check("fresh_estado", 32'(db_estado), 32'(3));
        check("fresh_jogada", 32'(jogada), 32'(4'b0010));
        botoes = 4'b0000;
        tick(10);
        check("fresh_queue", 32'(esperado.size()), 32'(0));

        // zera clears jogada on the next edge and leaves the FSM alone.
        zera = 1'b1;
        tick(1);
        zera = 1'b0;
        check("zera_jogada", 32'(jogada), 32'(0));
        check("zera_estado", 32'(db_estado), 32'(0));

        // zera on the same edge as the capture wins. The pulse still appears.
        botoes = 4'b0001;
        push_pulso(1'b0, 4'b0000);
        tick(7);
        zera = 1'b1;
        tick(1);
        zera = 1'b0;
        check("prio_jogada", 32'(jogada), 32'(0));
        check("prio_estado", 32'(db_estado), 32'(2));
        tick(3);
        botoes = 4'b0000;
        tick(10);
        check("prio_jogada_end", 32'(jogada), 32'(0));
        check("prio_queue", 32'(esperado.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
